count_display_driver: RTL and testbench

//   Downstream stage of the 12-bit up counter. Converts the free-running count (0..4095) to
//   4-digit BCD with a sequential shift-add-3 converter and drives a time-multiplexed
//   4-digit common-anode seven-segment display (active-low segments and anodes).

---
 rtl/count_display_driver_pkg.sv | 57 +++++
 rtl/count_display_driver_if.sv | 17 +
 rtl/count_display_driver_bin2bcd_seq.sv | 79 +++++++
 rtl/count_display_driver.sv | 77 +++++++
 tb/tb_count_display_driver.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_display_driver_pkg.sv
// Shared constants, state encodings and helpers for the count display driver.
package count_display_driver_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 12;
  localparam int BCD_W      = 16;
  localparam int CONV_STEPS = 12;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } conv_state_e;

  // Decimal digit to segments; non-decimal nibbles show nothing.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Shift-add-3 correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// Bundle between the counter / board pins and the display driver.
// No handshake: count_in is sampled freely; bcd_valid is a one-cycle strobe
// qualifying a fresh bcd value and has no ready/back-pressure.
interface count_display_driver_if;
  import count_display_driver_pkg::*;

  logic [BIN_W-1:0] count_in;
  logic [BCD_W-1:0] bcd;
  logic             bcd_valid;
  logic [6:0]       seg;
  logic             dp;
  logic [3:0]       an;
  conv_state_e      conv_state;

  modport master (output count_in, input bcd, bcd_valid, seg, dp, an, conv_state);
  modport slave  (input count_in, output bcd, bcd_valid, seg, dp, an, conv_state);
endinterface

// File: rtl/count_display_driver_bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter, one bit per cycle.
module bin2bcd_seq
  import count_display_driver_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             valid,
  output conv_state_e      state
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] shift_q;
  logic [BCD_W-1:0] scratch_q;
  logic [3:0]       iter_q;
  logic             load, step, done;
  logic [BCD_W-1:0] adj;

  assign adj   = add3_nibbles(scratch_q);
  assign state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: one capture, twelve shifts, one publish, then repeat
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_CONVERT;
      ST_CONVERT: if (iter_q == 4'(CONV_STEPS - 1)) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from state
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_IDLE:    load = 1'b1;
      ST_CONVERT: step = 1'b1;
      ST_DONE:    done = 1'b1;
      default:    load = 1'b0;
    endcase
  end

  // Shift-add-3 datapath; bcd only changes on completion so the display never sees partial values
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd       <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load) begin
        shift_q   <= bin;
        scratch_q <= '0;
        iter_q    <= '0;
      end
      if (step) begin
        {scratch_q, shift_q} <= {adj, shift_q} << 1;
        iter_q               <= iter_q + 4'd1;
      end
      if (done) begin
        bcd   <= scratch_q;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Count to BCD conversion plus multiplexed common-anode 7-segment drive.
module count_display_driver
  import count_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  count_display_driver_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       digit_sel_q;
  logic [BCD_W-1:0] bcd;
  logic             bcd_valid;
  logic [3:0]       nibble;
  logic             higher_zero;
  logic             blank;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .bin   (bus.count_in),
    .bcd   (bcd),
    .valid (bcd_valid),
    .state (bus.conv_state)
  );

  assign bus.bcd       = bcd;
  assign bus.bcd_valid = bcd_valid;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp        = 1'b1;

  // Refresh prescaler; each wrap advances to the next digit slot
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q   <= '0;
      digit_sel_q <= '0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q   <= '0;
      digit_sel_q <= digit_sel_q + 2'd1;
    end else begin
      refresh_q   <= refresh_q + 1'b1;
    end
  end

  // Digit select and leading-zero detection; the ones digit is never blanked
  always_comb begin
    nibble      = bcd[{digit_sel_q, 2'b00} +: 4];
    higher_zero = 1'b0;
    case (digit_sel_q)
      2'd1:    higher_zero = (bcd[15:4]  == 12'd0);
      2'd2:    higher_zero = (bcd[15:8]  == 8'd0);
      2'd3:    higher_zero = (bcd[15:12] == 4'd0);
      default: higher_zero = 1'b0;
    endcase
    blank = BLANK_LEAD && higher_zero;
  end

  // Registered anode and segment drive
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else begin
      an_q  <= ~(4'b0001 << digit_sel_q);
      seg_q <= blank ? SEG_BLANK : seg_encode(nibble);
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: two instances (leading-zero blanking on/off)
// checked every cycle against a decimal-arithmetic reference model.
module tb_count_display_driver;
  import count_display_driver_pkg::*;

  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] cin = 12'd0;
  always #5 clk = ~clk;

  count_display_driver_if bus_b ();
  count_display_driver_if bus_nb ();
  assign bus_b.count_in  = cin;
  assign bus_nb.count_in = cin;

  count_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus_b));
  count_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b0)) dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int p10 [4] = '{1, 10, 100, 1000};

  int          m_n = 0;
  int          m_cap = 0;
  int          m_val = 0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg_b = 7'h7F;
  logic [6:0]  m_seg_nb = 7'h7F;
  conv_state_e m_st = ST_IDLE;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Edge n after reset: sample count_in at n%14==1, publish at n%14==0;
  // display shows slot ((n-1)/DIV)%4 of the value published before this edge.
  always @(posedge clk) begin
    int slot, digit;
    if (reset) begin
      m_n = 0; m_val = 0; m_valid = 1'b0; m_an = 4'hF;
      m_seg_b = 7'h7F; m_seg_nb = 7'h7F; m_st = ST_IDLE;
    end else begin
      m_n++;
      slot  = ((m_n - 1) / DIV) % 4;
      digit = (m_val / p10[slot]) % 10;
      m_an  = ~(4'b0001 << slot);
      m_seg_nb = seg_tab[digit];
      m_seg_b  = (slot > 0 && m_val < p10[slot]) ? 7'h7F : seg_tab[digit];
      m_valid = 1'b0;
      if (m_n % 14 == 1) m_cap = int'(cin);
      if (m_n % 14 == 0) begin
        m_val   = m_cap;
        m_valid = 1'b1;
      end
      m_st = (m_n % 14 == 0) ? ST_IDLE : (m_n % 14 == 13) ? ST_DONE : ST_CONVERT;
    end
  end

  // ---------------- scoreboard vectors ----------------
  logic [61:0] obs_vec, exp_vec;
  assign obs_vec = {bus_b.bcd, bus_b.bcd_valid, bus_b.seg, bus_b.dp, bus_b.an, 2'(bus_b.conv_state),
                    bus_nb.bcd, bus_nb.bcd_valid, bus_nb.seg, bus_nb.dp, bus_nb.an, 2'(bus_nb.conv_state)};
  assign exp_vec = {to_bcd(m_val), m_valid, m_seg_b, 1'b1, m_an, 2'(m_st),
                    to_bcd(m_val), m_valid, m_seg_nb, 1'b1, m_an, 2'(m_st)};

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    cin = 12'd4095;
    repeat (3) @(negedge clk);
    total++;
    if (obs_vec !== exp_vec) begin
      bad++; $display("FAIL reset_model got=%h exp=%h", obs_vec, exp_vec);
    end
    total++;
    if ({bus_b.bcd, bus_b.bcd_valid, bus_b.seg, bus_b.an, bus_b.dp} !== {16'h0000, 1'b0, 7'h7F, 4'hF, 1'b1}) begin
      bad++; $display("FAIL reset_values got=%h/%b/%b/%b/%b exp=0000/0/1111111/1111/1",
                      bus_b.bcd, bus_b.bcd_valid, bus_b.seg, bus_b.an, bus_b.dp);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_scale;
    int last_v = 0;
    logic [6:0] want;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL full_scale cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (bus_b.bcd_valid) begin
        total++;
        if (i - last_v != 14) begin
          bad++; $display("FAIL valid_period cyc=%0d got=%0d exp=14", i, i - last_v);
        end
        last_v = i;
      end
      if (i >= 15) begin
        case (bus_b.an)
          4'b1110: want = 7'b0010010;
          4'b1101: want = 7'b0010000;
          4'b1011: want = 7'b1000000;
          4'b0111: want = 7'b0011001;
          default: want = 7'h00;
        endcase
        total++;
        if (bus_b.seg !== want || bus_b.bcd !== 16'h4095) begin
          bad++; $display("FAIL full_scale_seg cyc=%0d an=%b got=%b/%h exp=%b/4095", i, bus_b.an, bus_b.seg, bus_b.bcd, want);
        end
      end
    end
  endtask

  task automatic test_zero;
    cin = 12'd0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL zero cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i >= 32) begin
        total++;
        if (bus_b.bcd !== 16'h0000 || bus_b.seg !== (bus_b.an == 4'b1110 ? 7'b1000000 : 7'h7F) ||
            bus_nb.seg !== 7'b1000000) begin
          bad++; $display("FAIL zero_blank cyc=%0d an=%b got=%b/%b bcd=%h", i, bus_b.an, bus_b.seg, bus_nb.seg, bus_b.bcd);
        end
      end
    end
  endtask

  task automatic test_blank;
    logic [6:0] want;
    cin = 12'd7;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL blank7 cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i >= 32) begin
        want = (bus_b.an == 4'b1110) ? 7'b1111000 : 7'h7F;
        total++;
        if (bus_b.seg !== want) begin
          bad++; $display("FAIL blank7_seg cyc=%0d an=%b got=%b exp=%b", i, bus_b.an, bus_b.seg, want);
        end
      end
    end
    cin = 12'd1005;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL blank1005 cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i >= 32) begin
        case (bus_b.an)
          4'b1110: want = 7'b0010010;
          4'b1101: want = 7'b1000000;
          4'b1011: want = 7'b1000000;
          4'b0111: want = 7'b1111001;
          default: want = 7'h00;
        endcase
        total++;
        if (bus_b.seg !== want) begin
          bad++; $display("FAIL blank1005_seg cyc=%0d an=%b got=%b exp=%b", i, bus_b.an, bus_b.seg, want);
        end
      end
    end
  endtask

  task automatic test_midchange;
    int guard = 0;
    int seen = 0;
    logic [15:0] old_bcd;
    logic [15:0] got [2];
    got[0] = 16'hFFFF;
    got[1] = 16'hFFFF;
    while (!bus_b.bcd_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!bus_b.bcd_valid) begin
      bad++; $display("FAIL mid_align got=no_valid exp=valid_within_20");
    end
    old_bcd = bus_b.bcd;
    cin = 12'd1234;
    repeat (4) @(negedge clk);
    cin = 12'd2345;
    guard = 0;
    while (seen < 2 && guard < 40) begin
      @(negedge clk);
      guard++;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL midchange cyc=%0d got=%h exp=%h", guard, obs_vec, exp_vec);
      end
      total++;
      if (bus_b.bcd !== old_bcd && bus_b.bcd !== 16'h1234 && bus_b.bcd !== 16'h2345) begin
        bad++; $display("FAIL mid_torn cyc=%0d got=%h exp=%h/1234/2345", guard, bus_b.bcd, old_bcd);
      end
      if (bus_b.bcd_valid) begin
        got[seen] = bus_b.bcd;
        seen++;
      end
    end
    total++;
    if (got[0] !== 16'h1234 || got[1] !== 16'h2345) begin
      bad++; $display("FAIL mid_sequence got=%h,%h exp=1234,2345", got[0], got[1]);
    end
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    int lat = 0;
    while (!bus_b.bcd_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (bus_b.conv_state !== ST_CONVERT) begin
      bad++; $display("FAIL rmid_state got=%0d exp=%0d", bus_b.conv_state, ST_CONVERT);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_b.bcd, bus_b.bcd_valid, bus_b.seg, bus_b.an} !== {16'h0000, 1'b0, 7'h7F, 4'hF}) begin
      bad++; $display("FAIL rmid_values got=%h/%b/%b/%b exp=0000/0/1111111/1111",
                      bus_b.bcd, bus_b.bcd_valid, bus_b.seg, bus_b.an);
    end
    reset = 1'b0;
    cin = 12'($urandom_range(0, 4095));
    while (!bus_b.bcd_valid && lat < 30) begin
      @(negedge clk);
      lat++;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL rmid_model cyc=%0d got=%h exp=%h", lat, obs_vec, exp_vec);
      end
    end
    total++;
    if (lat != 14 || bus_b.bcd !== to_bcd(int'(cin))) begin
      bad++; $display("FAIL rmid_latency got=%0d/%h exp=14/%h", lat, bus_b.bcd, to_bcd(int'(cin)));
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 12; k++) begin
      cin = 12'($urandom_range(0, 4095));
      for (int i = 0; i < int'($urandom_range(5, 30)); i++) begin
        @(negedge clk);
        total++;
        if (obs_vec !== exp_vec) begin
          bad++; $display("FAIL random k=%0d cin=%0d got=%h exp=%h", k, cin, obs_vec, exp_vec);
        end
      end
    end
  endtask

  task automatic test_wrap;
    int guard = 0;
    cin = 12'd4095;
    while (bus_b.bcd !== 16'h4095 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (bus_b.bcd !== 16'h4095) begin
      bad++; $display("FAIL wrap_top got=%h exp=4095", bus_b.bcd);
    end
    cin = 12'd0;
    guard = 0;
    while (bus_b.bcd !== 16'h0000 && guard < 28) begin
      @(negedge clk);
      guard++;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", guard, obs_vec, exp_vec);
      end
    end
    total++;
    if (bus_b.bcd !== 16'h0000) begin
      bad++; $display("FAIL wrap_zero got=%h exp=0000 within 28", bus_b.bcd);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_scale();
    test_zero();
    test_blank();
    test_midchange();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
